lsu_arbiter: RTL and testbench
==============================

Name: lsu_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the load/store unit.
- Shares the single LSU port between master 0 (core datapath) and master 1 (debug loader / DMA).
- Latches each accepted request, drives the LSU for exactly one transaction, waits a programmable read latency, then returns data with a one-cycle valid pulse.
- Rejects misaligned or invalid-size accesses before they reach the LSU, so dmem and IO registers are never touched by illegal stores.

Parameters:
- RD_LATENCY, 1, cycles from LSU address presentation to valid i_lsu_ld_data (legal range 0..7).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- i_clk  in  1  clock; all flops rise on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_m0_req  in  1  master 0 request; held until o_m0_gnt.
- i_m0_addr  in  ADDR_W  master 0 byte address.
- i_m0_wdata  in  DATA_W  master 0 store data.
- i_m0_wren  in  1  master 0: 1 = store, 0 = load.
- i_m0_func3  in  3  master 0 size/sign code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- o_m0_gnt  out  1  one-cycle accept pulse to master 0.
- o_m0_rvalid  out  1  one-cycle completion pulse to master 0.
- o_m0_err  out  1  error flag, valid with o_m0_rvalid.
- i_m1_req, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_func3, o_m1_gnt, o_m1_rvalid, o_m1_err: same as master 0, for master 1.
- o_rdata  out  DATA_W  response data, valid with either rvalid.
- o_lsu_addr  out  ADDR_W  LSU address.
- o_lsu_st_data  out  DATA_W  LSU store data.
- o_lsu_wren  out  1  LSU write enable.
- o_lsu_func3  out  3  LSU size/sign code.
- i_lsu_ld_data  in  DATA_W  LSU load result.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: every output is 0; state = IDLE; last-served pointer = 1, so master 0 wins the first tie; latency counter = 0. Reset asserted mid-transaction aborts it: no rvalid is issued and o_lsu_wren drops immediately (asynchronously).
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No request pending: stay in IDLE; o_lsu_* = 0.
  - Exactly one request: grant that master.
  - Both requesting: grant the master that was not served last (round-robin).
  - On grant: pulse gnt for 1 cycle (the same cycle the grant is decided); latch addr, wdata, wren, func3 and master id; evaluate the error check; next state ACCESS.
- Error check:
  - func3 in {011, 110, 111} is an error.
  - Halfword with addr[0] = 1 is an error.
  - Word with addr[1:0] != 00 is an error.
  - Errored transactions skip ACCESS/WAIT: next state RESP with err = 1 and o_rdata = 0. The LSU is never driven.
- ACCESS (1 cycle):
  - o_lsu_addr, o_lsu_st_data and o_lsu_func3 come from the latched values.
  - o_lsu_wren = latched wren, asserted in this cycle only.
  - Counter loads RD_LATENCY.
  - If RD_LATENCY = 0, capture i_lsu_ld_data this cycle and go to RESP; otherwise go to WAIT.
- WAIT:
  - o_lsu_addr and o_lsu_func3 stay held; o_lsu_wren = 0.
  - Counter decrements each cycle. When it reaches 1, capture i_lsu_ld_data into o_rdata and go to RESP.
  - Stores also pass through WAIT; their captured data is forced to 0.
- RESP (1 cycle):
  - Pulse rvalid (and err if set) to the owning master.
  - o_rdata holds its value until the next capture.
  - Update the last-served pointer; next state IDLE.
- Latency and throughput:
  - Valid request → gnt: same cycle, while in IDLE.
  - Non-error transaction: gnt → rvalid = 2 + RD_LATENCY cycles.
  - Error transaction: gnt → rvalid = 1 cycle.
  - Back-to-back throughput: one transaction per 3 + RD_LATENCY cycles.
- Other rules:
  - Requests arriving outside IDLE are held off (no gnt); a master must keep req high.
  - A request dropped before gnt is simply not served.
  - gnt and rvalid are never asserted to both masters in the same cycle.

Optional Feature:
- Macro: LSU_ARB_LOCK_EN.
- Defined:
  - Adds ports i_m0_lock and i_m1_lock (1 bit each).
  - If the owning master's lock is high in RESP, the next IDLE arbitration considers only that master; the other master waits.
  - The lock lasts while lock stays high and the owner keeps requesting.
  - If the owner drops req while holding lock, the lock is released and normal round-robin resumes.
  - This supports atomic read-modify-write sequences on IO registers.
- Undefined: no lock ports; pure round-robin.

Test Plan:
- RD_LATENCY = 1; m0 lw addr 0x0000_0010, i_lsu_ld_data = 0xDEAD_BEEF → gnt at cycle t, o_lsu_wren = 0, m0_rvalid at t+3 with o_rdata = 0xDEAD_BEEF, err = 0.
- m0 and m1 both request from reset, m0 sw, m1 lw, holding req → order m0, m1, m0, m1. Each m1 rvalid with its load data; each m0 sw gives exactly one o_lsu_wren pulse with o_lsu_st_data = the written value.
- m1 lh addr 0x0000_0003 → gnt, rvalid and err = 1 one cycle later; o_rdata = 0; o_lsu_wren never asserted.
- m0 func3 = 3'b110 store → err = 1; no LSU write observed.
- Reset asserted in WAIT → all outputs 0 within the same cycle; no rvalid; next request served normally, with master 0 winning a tie.
- LSU_ARB_LOCK_EN defined; m1 lock = 1 for 3 loads while m0 requests continuously → m1 served 3 times, then m0 served after m1 releases lock.

Source files
------------

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares the single load/store unit port between master 0
// (core datapath) and master 1 (debug loader / DMA).
//
// Each accepted request is latched, then driven to the LSU for exactly one
// transaction. The arbiter then waits RD_LATENCY cycles and returns the data
// with a one-cycle rvalid pulse to the owning master. Misaligned or
// invalid-size accesses are rejected before the LSU is driven, so illegal
// stores never reach dmem or IO registers.
//
// Ports:
//   i_clk, i_reset           clock (posedge), async active-high reset
//   i_mN_req/addr/wdata/     master N request; req is held until o_mN_gnt
//     wren/func3
//   o_mN_gnt                 one-cycle accept pulse (same cycle as decision)
//   o_mN_rvalid, o_mN_err    one-cycle completion pulse and its error flag
//   o_rdata                  response data, valid with either rvalid
//   o_lsu_addr/st_data/      LSU request bus
//     wren/func3
//   i_lsu_ld_data            LSU load result
//   o_busy                   high whenever the sequencer is not idle
//
// Optional build macro LSU_ARB_LOCK_EN adds i_m0_lock / i_m1_lock. A master
// whose lock is high in its response cycle keeps exclusive ownership of the
// next arbitration for as long as it keeps requesting with lock high.
module lsu_arbiter #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
`ifdef LSU_ARB_LOCK_EN
  input  logic              i_m0_lock,
  input  logic              i_m1_lock,
`endif
  input  logic              i_m0_req,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m0_wren,
  input  logic [2:0]        i_m0_func3,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic              o_m0_err,
  input  logic              i_m1_req,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic              i_m1_wren,
  input  logic [2:0]        i_m1_func3,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic              o_m1_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_lsu_st_data,
  output logic              o_lsu_wren,
  output logic [2:0]        o_lsu_func3,
  input  logic [DATA_W-1:0] i_lsu_ld_data,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_e              state_q, state_d;
  logic                last_q, last_d;    // 1: master 1 was served last
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wren_q, wren_d;
  logic [2:0]          func3_q, func3_d;
  logic                id_q, id_d;        // owning master of the transaction
  logic                err_q, err_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                m0_elig, m1_elig;
  logic                pick_m1;
  logic                grant;
  logic [ADDR_W-1:0]   sel_addr;
  logic [2:0]          sel_func3;
  logic                req_err;

`ifdef LSU_ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic                lock_id_q, lock_id_d;
  logic                owner_req;
  logic                lock_hold;
`endif

  // Arbitration and request legality check.
  always_comb begin
`ifdef LSU_ARB_LOCK_EN
    // A held lock masks the other master only while its owner still requests.
    owner_req = lock_id_q ? i_m1_req : i_m0_req;
    lock_hold = lock_q & owner_req;
    m0_elig   = i_m0_req & ~(lock_hold & lock_id_q);
    m1_elig   = i_m1_req & ~(lock_hold & ~lock_id_q);
`else
    m0_elig   = i_m0_req;
    m1_elig   = i_m1_req;
`endif
    // Tie goes to the master not served last.
    pick_m1   = m1_elig & (~m0_elig | ~last_q);
    grant     = (state_q == S_IDLE) & (m0_elig | m1_elig);
    sel_addr  = pick_m1 ? i_m1_addr  : i_m0_addr;
    sel_func3 = pick_m1 ? i_m1_func3 : i_m0_func3;

    case (sel_func3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = sel_addr[0];
      3'b010:         req_err = (sel_addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = wren_q;
    func3_d = func3_q;
    id_d    = id_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef LSU_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef LSU_ARB_LOCK_EN
        if (lock_q && !owner_req) begin
          lock_d = 1'b0;
        end
`endif
        if (grant) begin
          addr_d  = sel_addr;
          wdata_d = pick_m1 ? i_m1_wdata : i_m0_wdata;
          wren_d  = pick_m1 ? i_m1_wren  : i_m0_wren;
          func3_d = sel_func3;
          id_d    = pick_m1;
          err_d   = req_err;
          if (req_err) begin
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = LAT;
        if (LAT == 3'd0) begin
          rdata_d = wren_q ? '0 : i_lsu_ld_data;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = wren_q ? '0 : i_lsu_ld_data;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = id_q;
`ifdef LSU_ARB_LOCK_EN
        lock_d    = id_q ? i_m1_lock : i_m0_lock;
        lock_id_d = id_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      func3_q <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef LSU_ARB_LOCK_EN
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      func3_q <= func3_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef LSU_ARB_LOCK_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

  // Grants are combinational from the live requests, so they are gated by
  // reset to keep every output low while reset is held.
  assign o_m0_gnt    = grant & ~pick_m1 & ~i_reset;
  assign o_m1_gnt    = grant &  pick_m1 & ~i_reset;
  assign o_m0_rvalid = (state_q == S_RESP) & ~id_q;
  assign o_m1_rvalid = (state_q == S_RESP) &  id_q;
  assign o_m0_err    = o_m0_rvalid & err_q;
  assign o_m1_err    = o_m1_rvalid & err_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = (state_q != S_IDLE);

  // Address and size stay on the bus through WAIT; write enable and store
  // data are only presented in the single ACCESS cycle.
  assign o_lsu_addr    = ((state_q == S_ACCESS) || (state_q == S_WAIT)) ? addr_q  : '0;
  assign o_lsu_func3   = ((state_q == S_ACCESS) || (state_q == S_WAIT)) ? func3_q : '0;
  assign o_lsu_st_data = (state_q == S_ACCESS) ? wdata_q : '0;
  assign o_lsu_wren    = (state_q == S_ACCESS) & wren_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
module tb_lsu_arbiter;

  localparam int unsigned LAT = 1;

  typedef struct packed {
    logic        m;
    logic [31:0] d;
    logic        e;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wren, m1_req, m1_wren;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_func3, m1_func3;
  logic        o_m0_gnt, o_m0_rvalid, o_m0_err;
  logic        o_m1_gnt, o_m1_rvalid, o_m1_err;
  logic [31:0] o_rdata, o_lsu_addr, o_lsu_st_data, ld_data;
  logic        o_lsu_wren, o_busy;
  logic [2:0]  o_lsu_func3;
`ifdef LSU_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  logic        use_fixed;
  logic [31:0] fixed_ld;

  int          checks = 0;
  int          fails  = 0;
  int unsigned cyc    = 0;
  int          wren_cnt = 0;

  resp_t        exp_q[$];
  logic [63:0]  st_obs[$];
  logic [63:0]  st_exp[$];
  logic         gnt_order[$];

  lsu_arbiter #(
    .RD_LATENCY(LAT),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
`ifdef LSU_ARB_LOCK_EN
    .i_m0_lock    (m0_lock),
    .i_m1_lock    (m1_lock),
`endif
    .i_m0_req     (m0_req),
    .i_m0_addr    (m0_addr),
    .i_m0_wdata   (m0_wdata),
    .i_m0_wren    (m0_wren),
    .i_m0_func3   (m0_func3),
    .o_m0_gnt     (o_m0_gnt),
    .o_m0_rvalid  (o_m0_rvalid),
    .o_m0_err     (o_m0_err),
    .i_m1_req     (m1_req),
    .i_m1_addr    (m1_addr),
    .i_m1_wdata   (m1_wdata),
    .i_m1_wren    (m1_wren),
    .i_m1_func3   (m1_func3),
    .o_m1_gnt     (o_m1_gnt),
    .o_m1_rvalid  (o_m1_rvalid),
    .o_m1_err     (o_m1_err),
    .o_rdata      (o_rdata),
    .o_lsu_addr   (o_lsu_addr),
    .o_lsu_st_data(o_lsu_st_data),
    .o_lsu_wren   (o_lsu_wren),
    .o_lsu_func3  (o_lsu_func3),
    .i_lsu_ld_data(ld_data),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: load data encodes the presented address.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  always_comb ld_data = use_fixed ? fixed_ld : mem_rd(o_lsu_addr);

  // Store observer and one-hot grant/response monitor.
  always @(negedge clk) begin
    if (o_lsu_wren === 1'b1) begin
      wren_cnt++;
      st_obs.push_back({o_lsu_addr, o_lsu_st_data});
    end
    checks++;
    if ((o_m0_gnt && o_m1_gnt) || (o_m0_rvalid && o_m1_rvalid)) begin
      fails++;
      $display("FAIL onehot: gnt=%b%b rvalid=%b%b required not both", o_m0_gnt, o_m1_gnt,
               o_m0_rvalid, o_m1_rvalid);
    end
  end

  task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic [2:0] f3,
                       output int unsigned gc, output bit ok);
    ok = 0;
    gc = 0;
    if (m) begin
      m1_addr = a; m1_wdata = wd; m1_wren = we; m1_func3 = f3; m1_req = 1'b1;
    end else begin
      m0_addr = a; m0_wdata = wd; m0_wren = we; m0_func3 = f3; m0_req = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((m ? o_m1_gnt : o_m0_gnt) === 1'b1) begin
        gc = cyc;
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic wait_resp(output logic m, output logic [31:0] d, output logic e,
                           output int unsigned at, output bit ok);
    ok = 0; m = 0; d = '0; e = 0; at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_m0_rvalid === 1'b1 || o_m1_rvalid === 1'b1) begin
        m  = o_m1_rvalid;
        d  = o_rdata;
        e  = o_m0_err | o_m1_err;
        at = cyc;
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    m0_addr = 32'h4; m1_addr = 32'h8; m0_wdata = '0; m1_wdata = '0;
    m0_wren = 1'b0; m1_wren = 1'b0; m0_func3 = 3'b010; m1_func3 = 3'b010;
    use_fixed = 1'b0; fixed_ld = '0;
`ifdef LSU_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if ({o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_err, o_m1_err, o_busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0000000", {o_m0_gnt, o_m1_gnt, o_m0_rvalid,
               o_m1_rvalid, o_m0_err, o_m1_err, o_busy});
    end
    checks++;
    if ({o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_func3} !== '0) begin
      fails++;
      $display("FAIL reset_lsu: got addr=%h st=%h wren=%b f3=%b required all 0",
               o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_func3);
    end
    checks++;
    if (o_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h required 00000000", o_rdata);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    resp_t r;
    logic  exp_ord[4];
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
    gnt_order.delete();
    st_obs.delete();
    st_exp.delete();
    fork
      begin : m0_proc
        bit got;
        for (int k = 0; k < 2; k++) begin
          m0_addr = 32'h100 + 32'(4 * k); m0_wdata = 32'hA000_0000 + 32'(k);
          m0_wren = 1'b1; m0_func3 = 3'b010; m0_req = 1'b1;
          got = 0;
          for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (o_m0_gnt === 1'b1) got = 1;
          end
          if (got) begin
            gnt_order.push_back(1'b0);
            exp_q.push_back({1'b0, 32'h0, 1'b0});
            st_exp.push_back({m0_addr, m0_wdata});
          end
          @(posedge clk); #1;
        end
        m0_req = 1'b0;
      end
      begin : m1_proc
        bit got;
        for (int k = 0; k < 2; k++) begin
          m1_addr = 32'h200 + 32'(4 * k); m1_wdata = 32'hFFFF_FFFF;
          m1_wren = 1'b0; m1_func3 = 3'b010; m1_req = 1'b1;
          got = 0;
          for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (o_m1_gnt === 1'b1) got = 1;
          end
          if (got) begin
            gnt_order.push_back(1'b1);
            exp_q.push_back({1'b1, mem_rd(m1_addr), 1'b0});
          end
          @(posedge clk); #1;
        end
        m1_req = 1'b0;
      end
      begin : resp_proc
        logic m, e; logic [31:0] d; int unsigned at; bit ok;
        for (int n = 0; n < 4; n++) begin
          wait_resp(m, d, e, at, ok);
          checks++;
          if (!ok || exp_q.size() == 0) begin
            fails++;
            $display("FAIL rr_resp%0d: got ok=%0d queued=%0d required a response", n, ok, exp_q.size());
          end else begin
            r = exp_q.pop_front();
            if ({m, d, e} !== {r.m, r.d, r.e}) begin
              fails++;
              $display("FAIL rr_resp%0d: got m=%b d=%h e=%b required m=%b d=%h e=%b",
                       n, m, d, e, r.m, r.d, r.e);
            end
          end
        end
      end
    join
    checks++;
    if (gnt_order.size() != 4) begin
      fails++;
      $display("FAIL rr_count: got %0d grants required 4", gnt_order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gnt_order[i] !== exp_ord[i]) begin
          fails++;
          $display("FAIL rr_order%0d: got m%0d required m%0d", i, gnt_order[i], exp_ord[i]);
        end
      end
    end
    checks++;
    if (st_obs.size() != st_exp.size() || st_obs.size() != 2) begin
      fails++;
      $display("FAIL rr_stores: got %0d wren pulses required 2", st_obs.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (st_obs[i] !== st_exp[i]) begin
          fails++;
          $display("FAIL rr_store%0d: got %h required %h", i, st_obs[i], st_exp[i]);
        end
      end
    end
  endtask

  task automatic test_single_load();
    int unsigned gc, at; bit ok; logic m, e; logic [31:0] d; resp_t r; int w0;
    use_fixed = 1'b1; fixed_ld = 32'hDEAD_BEEF;
    w0 = wren_cnt;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF, 1'b0});
    issue(1'b0, 32'h10, 32'h0, 1'b0, 3'b010, gc, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL load_gnt: got no grant required grant");
    end
    @(negedge clk);
    checks++;
    if ({o_lsu_addr, o_lsu_wren, o_lsu_func3, o_busy} !== {32'h10, 1'b0, 3'b010, 1'b1}) begin
      fails++;
      $display("FAIL load_access: got addr=%h wren=%b f3=%b busy=%b required 00000010 0 010 1",
               o_lsu_addr, o_lsu_wren, o_lsu_func3, o_busy);
    end
    wait_resp(m, d, e, at, ok);
    r = exp_q.pop_front();
    checks++;
    if (!ok || {m, d, e} !== {r.m, r.d, r.e}) begin
      fails++;
      $display("FAIL load_resp: got ok=%0d m=%b d=%h e=%b required m=%b d=%h e=%b",
               ok, m, d, e, r.m, r.d, r.e);
    end
    checks++;
    if (at - gc != 2 + LAT) begin
      fails++;
      $display("FAIL load_latency: got %0d cycles required %0d", at - gc, 2 + LAT);
    end
    checks++;
    if (wren_cnt != w0) begin
      fails++;
      $display("FAIL load_nowrite: got %0d wren pulses required 0", wren_cnt - w0);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_error_check();
    typedef struct packed {
      logic        m;
      logic [31:0] a;
      logic [2:0]  f3;
      logic        we;
      logic        err;
    } vec_t;
    vec_t vec[7];
    vec[0] = {1'b1, 32'h0000_0003, 3'b001, 1'b0, 1'b1};
    vec[1] = {1'b0, 32'h0000_0020, 3'b110, 1'b1, 1'b1};
    vec[2] = {1'b0, 32'h0000_0022, 3'b010, 1'b0, 1'b1};
    vec[3] = {1'b1, 32'h0000_0030, 3'b011, 1'b0, 1'b1};
    vec[4] = {1'b0, 32'h0000_0022, 3'b101, 1'b0, 1'b0};
    vec[5] = {1'b1, 32'h0000_0033, 3'b100, 1'b0, 1'b0};
    vec[6] = {1'b0, 32'h0000_0040, 3'b111, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      int unsigned gc, at; bit ok, okr; logic m, e; logic [31:0] d; resp_t r; int w0;
      w0 = wren_cnt;
      exp_q.push_back({vec[i].m, (vec[i].err || vec[i].we) ? 32'h0 : mem_rd(vec[i].a), vec[i].err});
      issue(vec[i].m, vec[i].a, 32'h5555_AAAA, vec[i].we, vec[i].f3, gc, ok);
      wait_resp(m, d, e, at, okr);
      r = exp_q.pop_front();
      checks++;
      if (!ok || !okr || {m, d, e} !== {r.m, r.d, r.e}) begin
        fails++;
        $display("FAIL err_vec%0d: got ok=%0d/%0d m=%b d=%h e=%b required m=%b d=%h e=%b",
                 i, ok, okr, m, d, e, r.m, r.d, r.e);
      end
      checks++;
      if (at - gc != (vec[i].err ? 1 : 2 + LAT)) begin
        fails++;
        $display("FAIL err_latency%0d: got %0d required %0d", i, at - gc, vec[i].err ? 1 : 2 + LAT);
      end
      checks++;
      if (wren_cnt - w0 != ((!vec[i].err && vec[i].we) ? 1 : 0)) begin
        fails++;
        $display("FAIL err_write%0d: got %0d wren pulses required %0d", i, wren_cnt - w0,
                 (!vec[i].err && vec[i].we) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int unsigned gc, at; bit ok; logic m, e; logic [31:0] d; int rv;
    issue(1'b0, 32'h50, 32'h0, 1'b0, 3'b010, gc, ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || {o_busy, o_lsu_wren, o_lsu_addr} !== {1'b1, 1'b0, 32'h50}) begin
      fails++;
      $display("FAIL wait_state: got ok=%0d busy=%b wren=%b addr=%h required 1 0 00000050",
               ok, o_busy, o_lsu_wren, o_lsu_addr);
    end
    m0_addr = 32'h54; m0_wren = 1'b0; m0_func3 = 3'b010; m0_req = 1'b1;
    m1_addr = 32'h58; m1_wren = 1'b0; m1_func3 = 3'b010; m1_req = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_err, o_m1_err, o_busy,
         o_lsu_wren, o_lsu_addr, o_lsu_st_data, o_lsu_func3, o_rdata} !== '0) begin
      fails++;
      $display("FAIL midreset_out: got busy=%b wren=%b addr=%h rdata=%h gnt=%b%b required all 0",
               o_busy, o_lsu_wren, o_lsu_addr, o_rdata, o_m0_gnt, o_m1_gnt);
    end
    rv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_m0_rvalid || o_m1_rvalid) rv++;
    end
    checks++;
    if (rv != 0) begin
      fails++;
      $display("FAIL midreset_norvalid: got %0d rvalid cycles required 0", rv);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    gc = cyc;
    checks++;
    if ({o_m0_gnt, o_m1_gnt} !== 2'b10) begin
      fails++;
      $display("FAIL midreset_tie: got gnt=%b%b required 10", o_m0_gnt, o_m1_gnt);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    wait_resp(m, d, e, at, ok);
    checks++;
    if (!ok || {m, d, e} !== {1'b0, mem_rd(32'h54), 1'b0} || at - gc != 2 + LAT) begin
      fails++;
      $display("FAIL midreset_resp: got ok=%0d m=%b d=%h e=%b lat=%0d required m=0 d=%h e=0 lat=%0d",
               ok, m, d, e, at - gc, mem_rd(32'h54), 2 + LAT);
    end
    issue(1'b1, 32'h58, 32'h0, 1'b0, 3'b010, gc, ok);
    wait_resp(m, d, e, at, ok);
    checks++;
    if (!ok || {m, d, e} !== {1'b1, mem_rd(32'h58), 1'b0}) begin
      fails++;
      $display("FAIL midreset_m1: got ok=%0d m=%b d=%h e=%b required m=1 d=%h e=0",
               ok, m, d, e, mem_rd(32'h58));
    end
  endtask

`ifdef LSU_ARB_LOCK_EN
  task automatic test_lock();
    resp_t r;
    logic  exp_ord[4];
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b0};
    gnt_order.delete();
    exp_q.delete();
    fork
      begin : m1_lock_proc
        bit got;
        m1_lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
          m1_addr = 32'h60 + 32'(4 * k); m1_wren = 1'b0; m1_func3 = 3'b010; m1_req = 1'b1;
          got = 0;
          for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (o_m1_gnt === 1'b1) got = 1;
          end
          if (got) begin
            gnt_order.push_back(1'b1);
            exp_q.push_back({1'b1, mem_rd(m1_addr), 1'b0});
          end
          @(posedge clk); #1;
        end
        m1_lock = 1'b0;
        m1_req  = 1'b0;
      end
      begin : m0_wait_proc
        bit got;
        for (int i = 0; i < 40 && gnt_order.size() == 0; i++) @(negedge clk);
        @(posedge clk); #1;
        m0_addr = 32'h70; m0_wren = 1'b0; m0_func3 = 3'b010; m0_req = 1'b1;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
          @(negedge clk);
          if (o_m0_gnt === 1'b1) got = 1;
        end
        if (got) begin
          gnt_order.push_back(1'b0);
          exp_q.push_back({1'b0, mem_rd(32'h70), 1'b0});
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
      end
      begin : lock_resp_proc
        logic m, e; logic [31:0] d; int unsigned at; bit ok;
        for (int n = 0; n < 4; n++) begin
          wait_resp(m, d, e, at, ok);
          checks++;
          if (!ok || exp_q.size() == 0) begin
            fails++;
            $display("FAIL lock_resp%0d: got ok=%0d queued=%0d required a response", n, ok, exp_q.size());
          end else begin
            r = exp_q.pop_front();
            if ({m, d, e} !== {r.m, r.d, r.e}) begin
              fails++;
              $display("FAIL lock_resp%0d: got m=%b d=%h e=%b required m=%b d=%h e=%b",
                       n, m, d, e, r.m, r.d, r.e);
            end
          end
        end
      end
    join
    checks++;
    if (gnt_order.size() != 4) begin
      fails++;
      $display("FAIL lock_count: got %0d grants required 4", gnt_order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gnt_order[i] !== exp_ord[i]) begin
          fails++;
          $display("FAIL lock_order%0d: got m%0d required m%0d", i, gnt_order[i], exp_ord[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_load();
    test_error_check();
    test_reset_mid_wait();
`ifdef LSU_ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
